// File: rtl/death_sequencer.sv
// Pac-Man collision check and death/eat sequencer.
// Freezes play, steps the death animation and pulses Restart.
module death_sequencer #(
   parameter int HIT_DIST         = 8,
   parameter int HIT_PAUSE_FRAMES = 60,
   parameter int DEATH_STEPS      = 11,
   parameter int FRAMES_PER_STEP  = 8,
   parameter int EAT_PAUSE_FRAMES = 30,
   parameter int GRACE_FRAMES     = 2
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        Frame_tick,
   input  logic        Game_active,
   input  logic [9:0]  Pac_X,
   input  logic [9:0]  Pac_Y,
   input  logic [39:0] Ghost_X,
   input  logic [39:0] Ghost_Y,
   input  logic [3:0]  Frightened,
   output logic        Freeze,
   output logic        Death_active,
   output logic [3:0]  Death_step,
   output logic        Ghost_eaten,
   output logic [1:0]  Eaten_id,
   output logic        Restart
);

   typedef enum logic [2:0] {
      PLAY,
      HIT_PAUSE,
      DYING,
      RESTART,
      GRACE,
      EAT_PAUSE
   } state_t;

   state_t     state;
   logic [7:0] fcnt;
   logic [3:0] hit;
   logic       lethal;
   logic [3:0] edible;
   logic [1:0] eat_id;

   // Per-ghost distance on each axis, 11-bit two's complement
   for (genvar g = 0; g < 4; g++) begin : g_hit
      logic [10:0] dx;
      logic [10:0] dy;
      logic [10:0] ax;
      logic [10:0] ay;
      assign dx = {1'b0, Pac_X} - {1'b0, Ghost_X[10*g +: 10]};
      assign dy = {1'b0, Pac_Y} - {1'b0, Ghost_Y[10*g +: 10]};
      assign ax = dx[10] ? (~dx + 11'd1) : dx;
      assign ay = dy[10] ? (~dy + 11'd1) : dy;
      assign hit[g] = (ax < 11'(HIT_DIST)) && (ay < 11'(HIT_DIST));
   end

   assign lethal = |(hit & ~Frightened);
   assign edible = hit & Frightened;

   always_comb begin
      eat_id = 2'd0;
      for (int i = 3; i >= 0; i--) begin
         if (edible[i]) eat_id = 2'(i);
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state        <= PLAY;
         fcnt         <= 8'd0;
         Freeze       <= 1'b0;
         Death_active <= 1'b0;
         Death_step   <= 4'd0;
         Ghost_eaten  <= 1'b0;
         Eaten_id     <= 2'd0;
         Restart      <= 1'b0;
      end else begin
         Ghost_eaten <= 1'b0;
         Restart     <= 1'b0;
         unique case (state)
            PLAY: begin
               if (Frame_tick && Game_active) begin
                  if (lethal) begin
                     state  <= HIT_PAUSE;
                     fcnt   <= 8'd0;
                     Freeze <= 1'b1;
                  end else if (|edible) begin
                     state       <= EAT_PAUSE;
                     fcnt        <= 8'd0;
                     Freeze      <= 1'b1;
                     Eaten_id    <= eat_id;
                     Ghost_eaten <= 1'b1;
                  end
               end
            end
            HIT_PAUSE: begin
               if (Frame_tick) begin
                  if (fcnt == 8'(HIT_PAUSE_FRAMES - 1)) begin
                     state        <= DYING;
                     fcnt         <= 8'd0;
                     Death_step   <= 4'd0;
                     Death_active <= 1'b1;
                  end else begin
                     fcnt <= fcnt + 8'd1;
                  end
               end
            end
            DYING: begin
               if (Frame_tick) begin
                  if (fcnt == 8'(FRAMES_PER_STEP - 1)) begin
                     fcnt <= 8'd0;
                     if (Death_step == 4'(DEATH_STEPS - 1)) begin
                        state        <= RESTART;
                        Death_active <= 1'b0;
                        Restart      <= 1'b1;
                     end else begin
                        Death_step <= Death_step + 4'd1;
                     end
                  end else begin
                     fcnt <= fcnt + 8'd1;
                  end
               end
            end
            // Single-clock state; Frame_tick deliberately ignored
            RESTART: begin
               state      <= GRACE;
               fcnt       <= 8'd0;
               Death_step <= 4'd0;
            end
            GRACE: begin
               if (Frame_tick) begin
                  if (fcnt == 8'(GRACE_FRAMES - 1)) begin
                     state  <= PLAY;
                     fcnt   <= 8'd0;
                     Freeze <= 1'b0;
                  end else begin
                     fcnt <= fcnt + 8'd1;
                  end
               end
            end
            EAT_PAUSE: begin
               if (Frame_tick) begin
                  if (fcnt == 8'(EAT_PAUSE_FRAMES - 1)) begin
                     state  <= PLAY;
                     fcnt   <= 8'd0;
                     Freeze <= 1'b0;
                  end else begin
                     fcnt <= fcnt + 8'd1;
                  end
               end
            end
            default: begin
               state  <= PLAY;
               fcnt   <= 8'd0;
               Freeze <= 1'b0;
            end
         endcase
      end
   end

endmodule
